// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  ovf,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_reg, state_next;
   logic [BCD_W-1:0]   digit_reg, digit_shift, digit_adj;
   logic [BIN_W-1:0]   bin_reg, bin_shift, bin_out_reg, fin_bin;
   logic [CNT_W-1:0]   cnt_reg;
   logic               ovf_reg, fin_ovf;
   logic               accept, last_iter;

   genvar gi;

   assign {digit_shift, bin_shift} = {digit_reg, bin_reg} >> 1;

   // After the shift, any digit >= 8 held a carried-in half-ten; subtracting 3 restores it to BCD.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign digit_adj[4*gi +: 4] = digit_shift[4*gi + 3] ? (digit_shift[4*gi +: 4] - 4'd3)
                                                              : digit_shift[4*gi +: 4];
      end
   endgenerate

   assign ready     = (state_reg == IDLE) || (state_reg == DONE);
   assign busy      = (state_reg == SHIFT);
   assign done      = (state_reg == DONE);
   assign accept    = start && ready;
   assign last_iter = (state_reg == SHIFT) && (cnt_reg == CNT_W'(BIN_W - 1));
   assign bin_out   = bin_out_reg;
   assign ovf       = ovf_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_iter) state_next = DONE;
         DONE:    state_next = start ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

`ifdef BCD_DIGIT_CHECK_EN
   logic [DIGITS-1:0] digit_bad;
   logic              err_pending_reg, err_reg;

   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_chk
         assign digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
      end
   endgenerate

   assign fin_bin = err_pending_reg ? '0 : bin_shift;
   assign fin_ovf = ~err_pending_reg & (|digit_adj);
   assign err     = err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pending_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else if (accept) begin
         err_pending_reg <= |digit_bad;
         err_reg         <= 1'b0;
      end else if (last_iter) begin
         err_reg         <= err_pending_reg;
      end
   end
`else
   assign fin_bin = bin_shift;
   assign fin_ovf = |digit_adj;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         digit_reg   <= '0;
         bin_reg     <= '0;
         cnt_reg     <= '0;
         bin_out_reg <= '0;
         ovf_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            digit_reg <= bcd_in;
            bin_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
         end else if (state_reg == SHIFT) begin
            digit_reg <= digit_adj;
            bin_reg   <= bin_shift;
            cnt_reg   <= cnt_reg + 1'b1;
            // Any digit content left after BIN_W shifts is value beyond 2^BIN_W.
            if (last_iter) begin
               bin_out_reg <= fin_bin;
               ovf_reg     <= fin_ovf;
            end
         end
      end
   end

endmodule
